// File: rtl/text_pixel_gen.sv
// Text-mode pixel generator: fetches char/attr and glyph row per cell and serialises 8 pixels
// through the CGA palette, one cell behind the CRTC. Optional blink attribute: BLINK_ATTR_EN.
module text_pixel_gen #(
  parameter int unsigned COLS      = 80,
  parameter logic        SYNC_IDLE = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        pix_stb_i,
  input  logic        col_stb_i,
  input  logic [6:0]  col_i,
  input  logic [8:0]  line_i,
  input  logic        cursor_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        video_on_i,
  output logic [11:0] vram_addr_o,
  output logic        vram_rd_o,
  input  logic [15:0] vram_data_i,
  output logic [11:0] font_addr_o,
  input  logic [7:0]  font_data_i,
  output logic [11:0] rgb_o,
  output logic        hsync_o,
  output logic        vsync_o
);

  typedef enum logic [1:0] {S_IDLE, S_VRAM_WAIT, S_FONT_REQ, S_FONT_WAIT} state_t;

  localparam logic [11:0] COLS_W = 12'(COLS);

  state_t      r_state, w_state_nxt;
  logic        w_font_req, w_font_cap;
  logic [11:0] w_vram_addr;

  logic        r_pend;
  logic [3:0]  r_f_line;
  logic        r_f_cursor, r_f_hs, r_f_vs, r_f_von;
  logic [7:0]  r_f_attr;

  logic [7:0]  r_s_pat, r_s_attr;
  logic        r_s_hs, r_s_vs, r_s_von;

  logic [7:0]  r_shift, r_out_attr;
  logic        r_von_d;
  logic [7:0]  w_shift_nxt, w_attr_nxt;
  logic        w_von_nxt;
  logic [3:0]  w_fg_idx, w_bg_idx;
  logic [11:0] w_rgb_nxt;

  function automatic logic [11:0] pal(input logic [3:0] idx);
    case (idx)
      4'h0: pal = 12'h000;  4'h1: pal = 12'h00A;  4'h2: pal = 12'h0A0;  4'h3: pal = 12'h0AA;
      4'h4: pal = 12'hA00;  4'h5: pal = 12'hA0A;  4'h6: pal = 12'hA50;  4'h7: pal = 12'hAAA;
      4'h8: pal = 12'h555;  4'h9: pal = 12'h55F;  4'hA: pal = 12'h5F5;  4'hB: pal = 12'h5FF;
      4'hC: pal = 12'hF55;  4'hD: pal = 12'hF5F;  4'hE: pal = 12'hFF5;  default: pal = 12'hFFF;
    endcase
  endfunction

  // Row stride is a constant, so the multiply reduces to shift-add (80 = 64 + 16)
  assign w_vram_addr = {7'd0, line_i[8:4]} * COLS_W + {5'd0, col_i};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_font_req  = 1'b0;
    w_font_cap  = 1'b0;
    if (col_stb_i) begin
      w_state_nxt = S_VRAM_WAIT;
    end else begin
      case (r_state)
        S_VRAM_WAIT: w_state_nxt = S_FONT_REQ;
        S_FONT_REQ: begin
          w_state_nxt = S_FONT_WAIT;
          w_font_req  = 1'b1;
        end
        S_FONT_WAIT: w_state_nxt = S_IDLE;
        default: begin
          w_state_nxt = S_IDLE;
          w_font_cap  = r_pend;
        end
      endcase
    end
  end

  // Fetch side; a restart before the glyph capture leaves the staging registers untouched
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vram_addr_o <= '0;
      vram_rd_o   <= 1'b0;
      font_addr_o <= '0;
      r_pend      <= 1'b0;
      r_f_line    <= '0;
      r_f_cursor  <= 1'b0;
      r_f_hs      <= SYNC_IDLE;
      r_f_vs      <= SYNC_IDLE;
      r_f_von     <= 1'b0;
      r_f_attr    <= '0;
      r_s_pat     <= '0;
      r_s_attr    <= '0;
      r_s_hs      <= SYNC_IDLE;
      r_s_vs      <= SYNC_IDLE;
      r_s_von     <= 1'b0;
    end else begin
      vram_rd_o <= col_stb_i;
      if (col_stb_i) begin
        vram_addr_o <= w_vram_addr;
        r_f_line    <= line_i[3:0];
        r_f_cursor  <= cursor_i;
        r_f_hs      <= hsync_i;
        r_f_vs      <= vsync_i;
        r_f_von     <= video_on_i;
        r_pend      <= 1'b0;
      end else if (r_state == S_FONT_WAIT) begin
        r_pend <= 1'b1;
      end else if (w_font_cap) begin
        r_pend <= 1'b0;
      end
      if (w_font_req) begin
        r_f_attr    <= vram_data_i[15:8];
        font_addr_o <= {vram_data_i[7:0], r_f_line};
      end
      if (w_font_cap) begin
        r_s_pat  <= font_data_i ^ {8{r_f_cursor}};
        r_s_attr <= r_f_attr;
        r_s_hs   <= r_f_hs;
        r_s_vs   <= r_f_vs;
        r_s_von  <= r_f_von;
      end
    end
  end

`ifdef BLINK_ATTR_EN
  logic       r_vsync_q;
  logic [4:0] r_frame_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_vsync_q   <= SYNC_IDLE;
      r_frame_cnt <= '0;
    end else begin
      r_vsync_q <= vsync_i;
      if (r_vsync_q && !vsync_i) r_frame_cnt <= r_frame_cnt + 5'd1;
    end
  end
`endif

  // rgb is computed from the post-edge shift/attr so a load edge emits bit 7 of the new cell
  always_comb begin
    if (col_stb_i) begin
      w_shift_nxt = r_s_pat;
      w_attr_nxt  = r_s_attr;
      w_von_nxt   = r_s_von;
    end else begin
      w_shift_nxt = {r_shift[6:0], 1'b0};
      w_attr_nxt  = r_out_attr;
      w_von_nxt   = r_von_d;
    end
    w_fg_idx = w_attr_nxt[3:0];
`ifdef BLINK_ATTR_EN
    w_bg_idx = {1'b0, w_attr_nxt[6:4]};
    if (w_attr_nxt[7] && r_frame_cnt[4]) w_fg_idx = w_bg_idx;
`else
    w_bg_idx = w_attr_nxt[7:4];
`endif
    w_rgb_nxt = '0;
    if (w_von_nxt) w_rgb_nxt = pal(w_shift_nxt[7] ? w_fg_idx : w_bg_idx);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_shift    <= '0;
      r_out_attr <= '0;
      r_von_d    <= 1'b0;
      rgb_o      <= '0;
      hsync_o    <= SYNC_IDLE;
      vsync_o    <= SYNC_IDLE;
    end else if (col_stb_i || pix_stb_i) begin
      r_shift    <= w_shift_nxt;
      r_out_attr <= w_attr_nxt;
      r_von_d    <= w_von_nxt;
      rgb_o      <= w_rgb_nxt;
      if (col_stb_i) begin
        hsync_o <= r_s_hs;
        vsync_o <= r_s_vs;
      end
    end
  end

endmodule

// File: tb/tb_text_pixel_gen.sv
// Directed bench for text_pixel_gen with behavioural VRAM/font ROM models and hand-computed pixels.
module tb_text_pixel_gen;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        pix_stb_i = 1'b0, col_stb_i = 1'b0;
  logic [6:0]  col_i = '0;
  logic [8:0]  line_i = '0;
  logic        cursor_i = 1'b0, hsync_i = 1'b1, vsync_i = 1'b1, video_on_i = 1'b0;
  logic [11:0] vram_addr_o, font_addr_o, rgb_o;
  logic        vram_rd_o, hsync_o, vsync_o;
  logic [15:0] vram_data_i = '0;
  logic [7:0]  font_data_i = '0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [15:0] m_word  = '0;
  logic [7:0]  m_glyph = '0;
  logic [11:0] m_vaddr = '0, m_faddr = '0;
  logic [11:0] exp_px [8];

  text_pixel_gen #(.COLS(80), .SYNC_IDLE(1'b1)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .pix_stb_i(pix_stb_i), .col_stb_i(col_stb_i),
    .col_i(col_i), .line_i(line_i), .cursor_i(cursor_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .video_on_i(video_on_i), .vram_addr_o(vram_addr_o), .vram_rd_o(vram_rd_o),
    .vram_data_i(vram_data_i), .font_addr_o(font_addr_o), .font_data_i(font_data_i),
    .rgb_o(rgb_o), .hsync_o(hsync_o), .vsync_o(vsync_o)
  );

  always #5 clk_i = ~clk_i;

  // Memories answer only at the expected address, so a wrong address shows up as wrong pixels
  always @(posedge clk_i) begin
    if (vram_rd_o) vram_data_i <= (vram_addr_o == m_vaddr) ? m_word : 16'h0000;
    font_data_i <= (font_addr_o == m_faddr) ? m_glyph : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_cell(input logic [6:0] col, input logic [8:0] line, input logic cur,
                          input logic hs, input logic vs, input logic von,
                          input logic [15:0] word, input logic [7:0] glyph,
                          input logic exp_hs, input logic exp_vs, input logic chk_sync,
                          input logic [11:0] exp_vaddr, input logic [11:0] exp_faddr);
    m_word = word; m_glyph = glyph; m_vaddr = exp_vaddr; m_faddr = exp_faddr;
    col_i = col; line_i = line; cursor_i = cur; hsync_i = hs; vsync_i = vs; video_on_i = von;
    for (int p = 0; p < 8; p++) begin
      pix_stb_i = 1'b1;
      col_stb_i = (p == 0);
      @(posedge clk_i); #1;
      pix_stb_i = 1'b0;
      col_stb_i = 1'b0;
      check($sformatf("rgb[%0d]", p), 32'(rgb_o), 32'(exp_px[p]));
      if (p == 0) begin
        if (chk_sync) begin
          check("hsync_o", 32'(hsync_o), 32'(exp_hs));
          check("vsync_o", 32'(vsync_o), 32'(exp_vs));
        end
        check("vram_rd_E0", 32'(vram_rd_o), 32'd1);
        check("vram_addr", 32'(vram_addr_o), 32'(exp_vaddr));
      end
      @(posedge clk_i); #1;
      if (p == 0) check("vram_rd_E1", 32'(vram_rd_o), 32'd0);
      @(posedge clk_i); #1;
      if (p == 0) check("font_addr", 32'(font_addr_o), 32'(exp_faddr));
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_rgb", 32'(rgb_o), 32'h0);
    check("rst_hsync", 32'(hsync_o), 32'd1);
    check("rst_vsync", 32'(vsync_o), 32'd1);
    check("rst_vram_rd", 32'(vram_rd_o), 32'd0);
    rst_n_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      check("idle_vram_rd", 32'(vram_rd_o), 32'd0);
      check("idle_rgb", 32'(rgb_o), 32'h0);
    end

    // Cell 1: output shows the reset staging (video off)
    exp_px = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};
    run_cell(7'd5, 9'd37, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1F41, 8'hC3, 1'b1, 1'b1, 1'b0, 12'd165, 12'h415);

    // Cell 2 (cursor): output shows cell 1, glyph C3 attr 1F
    exp_px = '{12'hFFF, 12'hFFF, 12'h00A, 12'h00A, 12'h00A, 12'h00A, 12'hFFF, 12'hFFF};
    run_cell(7'd5, 9'd37, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1F41, 8'hC3, 1'b1, 1'b1, 1'b1, 12'd165, 12'h415);

    // Cell 3 (video off, hsync low): output shows cursor-inverted cell 2
    exp_px = '{12'h00A, 12'h00A, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h00A, 12'h00A};
    run_cell(7'd0, 9'd16, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1F41, 8'hC3, 1'b1, 1'b1, 1'b1, 12'd80, 12'h410);

`ifdef BLINK_ATTR_EN
    for (int i = 0; i < 16; i++) begin
      vsync_i = 1'b0; @(posedge clk_i); #1;
      vsync_i = 1'b1; @(posedge clk_i); #1;
    end
`endif

    // Cell 4 (attr 9E, glyph 0F): output shows blanked cell 3 with hsync low
    exp_px = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};
    run_cell(7'd10, 9'd100, 1'b0, 1'b1, 1'b1, 1'b1, 16'h9E41, 8'h0F, 1'b0, 1'b1, 1'b1, 12'd490, 12'h414);

    // Cell 5: output shows cell 4
`ifdef BLINK_ATTR_EN
    exp_px = '{12'h00A, 12'h00A, 12'h00A, 12'h00A, 12'h00A, 12'h00A, 12'h00A, 12'h00A};
`else
    exp_px = '{12'h55F, 12'h55F, 12'h55F, 12'h55F, 12'hFF5, 12'hFF5, 12'hFF5, 12'hFF5};
`endif
    run_cell(7'd5, 9'd37, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1F41, 8'hC3, 1'b1, 1'b1, 1'b1, 12'd165, 12'h415);

    // Cell 6 at the last column/row: max address 2399
    exp_px = '{12'hFFF, 12'hFFF, 12'h00A, 12'h00A, 12'h00A, 12'h00A, 12'hFFF, 12'hFFF};
    run_cell(7'd79, 9'd479, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1F41, 8'hC3, 1'b1, 1'b0, 1'b1, 12'd2399, 12'h41F);

    // Asynchronous reset while outputs are active
    rst_n_i = 1'b0;
    #1;
    check("arst_rgb", 32'(rgb_o), 32'h0);
    check("arst_vsync", 32'(vsync_o), 32'd1);
    check("arst_vram_addr", 32'(vram_addr_o), 32'h0);
    check("arst_font_addr", 32'(font_addr_o), 32'h0);
    repeat (2) @(posedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/text_pixel_gen.md
Name: text_pixel_gen

Overview:
- Consumer of the CRTC timing outputs: turns per-character-cell column/line coordinates into 640x480 text-mode pixels.
- For each cell it fetches the character/attribute word from video RAM and the glyph row from font ROM, then serialises 8 pixels through a 16-colour palette.
- Outputs are 12-bit RGB plus syncs, delayed exactly one character cell so that syncs stay aligned with pixels.
- Sits between CRTC, VRAM read port, font ROM and the VGA DAC pins.

Parameters:
- COLS, 80, characters per text row (VRAM row stride).
- SYNC_IDLE, 1'b1, reset value of hsync_o/vsync_o (inactive level).

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- pix_stb_i  in  1  one-clk pulse per pixel
- col_stb_i  in  1  one-clk pulse at first pixel of each cell; always coincides with pix_stb_i
- col_i  in  7  character column 0..79
- line_i  in  9  scan line 0..479
- cursor_i  in  1  cell is under the visible cursor
- hsync_i  in  1  CRTC horizontal sync
- vsync_i  in  1  CRTC vertical sync
- video_on_i  in  1  CRTC active-video flag
- vram_addr_o  out  12  VRAM word address
- vram_rd_o  out  1  VRAM read strobe
- vram_data_i  in  16  {attr[7:0], char[7:0]}; synchronous, 1-clk latency
- font_addr_o  out  12  {char[7:0], line[3:0]}
- font_data_i  in  8  glyph row, MSB = leftmost pixel; synchronous, 1-clk latency
- rgb_o  out  12  {R[3:0], G[3:0], B[3:0]}
- hsync_o  out  1  delayed hsync
- vsync_o  out  1  delayed vsync

Behaviour:
- Clocking and reset: single clock clk_i. Reset is asynchronous, active-low on rst_n_i.
- Reset values:
  - rgb_o = 0, vram_rd_o = 0, vram_addr_o = 0, font_addr_o = 0.
  - hsync_o = vsync_o = SYNC_IDLE.
  - FSM in IDLE; staging and shift registers = 0; delayed video_on = 0.
- Fetch FSM: IDLE -> VRAM_WAIT -> FONT_REQ -> FONT_WAIT -> IDLE. Edges E0..E4, with E0 = the clk edge that samples col_stb_i = 1.
  - E0: register vram_addr_o = line_i[8:4]*COLS + col_i (shift-add, 12 bits; max 2399). Set vram_rd_o = 1 for one clk. Latch cursor_i, hsync_i, vsync_i, video_on_i into fetch registers. Go to VRAM_WAIT.
  - E1: go to FONT_REQ.
  - E2: latch char/attr from vram_data_i. Register font_addr_o = {char, line_i[3:0] as latched at E0}. Go to FONT_WAIT.
  - E3: go to IDLE.
  - E4 (sampled in IDLE): latch font_data_i into staging pattern. If the latched cursor = 1, store the pattern XOR 8'hFF.
- Minimum col_stb_i spacing is 5 clks.
  - If col_stb_i arrives before the fetch has reached E4, the fetch restarts from E0.
  - The staging register keeps its previous contents in that case.
- Output stage, on each col_stb_i edge:
  - shift_reg <= staging pattern; out_attr <= staging attr.
  - hsync_o, vsync_o and video_on_d <= the values latched for that staged cell.
  - This gives a latency of exactly one cell (8 pixels).
- Output stage, on a pix_stb_i edge without col_stb_i: shift_reg <= shift_reg << 1.
- rgb_o is registered and updated on every pix_stb_i edge from the pixel being emitted. At a load edge that pixel is bit 7 of the new pattern.
  - video_on_d = 0 -> rgb_o = 0.
  - pixel = 1 -> PAL(fg = attr[3:0]).
  - pixel = 0 -> PAL(bg).
- PAL is a fixed CGA 16-entry table:
  - 0 = 000, 1 = 00A, 2 = 0A0, 3 = 0AA, 4 = A00, 5 = A0A, 6 = A50, 7 = AAA.
  - 8 = 555, 9 = 55F, A = 5F5, B = 5FF, C = F55, D = F5F, E = FF5, F = FFF.
- Background index depends on BLINK_ATTR_EN (see Optional Feature).
- Between pix_stb_i pulses, all outputs hold.
- Reset mid-cell: everything returns to reset values immediately. The first valid output follows the second col_stb_i after reset release.

Optional Feature:
- BLINK_ATTR_EN defined:
  - attr[7] is the blink bit; bg = {1'b0, attr[6:4]}.
  - A 5-bit frame counter increments on each falling edge of vsync_i, detected via a registered copy.
  - When attr[7] = 1 and counter[4] = 1, foreground pixels show bg colour.
- Not defined:
  - No counter is built; bg = attr[7:4] (16 background colours).

Test Plan:
- Reset then release, no strobes -> rgb_o = 0, hsync_o = vsync_o = 1, vram_rd_o never asserted.
- col_stb_i with col_i = 5, line_i = 37 -> vram_addr_o = 12'd165 and vram_rd_o = 1 for one clk after E0. Then with vram_data_i = 16'h1F41, font_addr_o = 12'h415 after E2.
- font_data_i = 8'hC3, attr 0x1F, video_on = 1, pix_stb every 4 clks -> the next cell outputs FFF,FFF,00A,00A,00A,00A,FFF,FFF.
- Same cell with cursor_i = 1 -> pattern 8'h3C, pixels 00A,00A,FFF,FFF,FFF,FFF,00A,00A.
- video_on_i = 0 and hsync_i = 0 at a strobe -> rgb_o = 0 for 8 pixels and hsync_o = 0 one cell later, matching pixel alignment.
- BLINK_ATTR_EN with attr 0x9E after 16 vsync falls -> fg pixels = 00A (bg). Without the macro, the same attr gives bg = 55F.
